// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit half of the UART monitor. Characters from the character encoder
// are queued in a small circular buffer and serialized onto the TX pin as
// 8N1 frames (one start bit, eight data bits LSB first, one stop bit). Each
// bit lasts BAUD_DIV clocks. The full flag is the encoder's only flow
// control.
//
// Parameters:
//   DEPTH_LOG2   - log2 of the queue depth (default 4 -> 16 entries)
//   BAUD_DIV     - clocks per UART bit, 2..65535 (default 434 = 50 MHz/115200)
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   rst          - synchronous active-high reset; aborts any frame in flight
//   send_char    - character to enqueue
//   send_en      - enqueue strobe; ignored while the queue is full
//   tx_fifo_full - queue holds 2^DEPTH_LOG2 characters
//   tx_busy      - queue non-empty or a frame is on the line
//   uart_tx      - registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BAUD_DIV   = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] send_char,
  input  logic       send_en,
  output logic       tx_fifo_full,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO    = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [15:0]           BAUD_RELOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Queue storage and bookkeeping
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [CNT_W-1:0]      count;

  // Serializer state
  state_t      state;
  state_t      state_nxt;
  logic [15:0] bcnt;
  logic [15:0] bcnt_nxt;
  logic [2:0]  bitidx;
  logic [2:0]  bitidx_nxt;
  logic [7:0]  shift;
  logic [7:0]  shift_nxt;
  logic        tx_nxt;

  logic        pop;
  logic        wr_en;
  logic        fifo_empty;
  logic        bit_end;

  // The full test uses the registered count, so a write arriving in the same
  // cycle as a pop from a full queue is still refused.
  assign tx_fifo_full = (count == CNT_FULL);
  assign fifo_empty   = (count == CNT_ZERO);
  assign wr_en        = send_en & ~tx_fifo_full;
  assign bit_end      = (bcnt == 16'd0);
  assign tx_busy      = (state != IDLE) || !fifo_empty;

  // Storage array has no reset; its contents are only meaningful between
  // the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= send_char;
    end
  end

  // Pointer and occupancy tracking. A write and a pop in the same cycle
  // leave the occupancy unchanged while both pointers move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Serializer registers. The line itself is registered so the pin never
  // glitches; its next value is decided together with the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bitidx  <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      bcnt    <= bcnt_nxt;
      bitidx  <= bitidx_nxt;
      shift   <= shift_nxt;
      uart_tx <= tx_nxt;
    end
  end

  // Next-state logic. The baud counter reloads whenever a new bit starts and
  // counts down otherwise; reaching zero marks the last clock of a bit. The
  // stop bit chains straight into the next start bit when more characters
  // are waiting, giving gap-free back-to-back frames.
  always_comb begin
    state_nxt  = state;
    bcnt_nxt   = bcnt;
    bitidx_nxt = bitidx;
    shift_nxt  = shift;
    tx_nxt     = uart_tx;
    pop        = 1'b0;

    if (state != IDLE && !bit_end) begin
      bcnt_nxt = bcnt - 16'd1;
    end

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rptr];
          state_nxt = START;
          bcnt_nxt  = BAUD_RELOAD;
          tx_nxt    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_nxt  = DATA;
          bitidx_nxt = 3'd0;
          bcnt_nxt   = BAUD_RELOAD;
          tx_nxt     = shift[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          bcnt_nxt = BAUD_RELOAD;
          if (bitidx != 3'd7) begin
            bitidx_nxt = bitidx + 3'd1;
            shift_nxt  = {1'b0, shift[7:1]};
            tx_nxt     = shift[1];
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          bcnt_nxt = BAUD_RELOAD;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit side of the UART monitor. It buffers ASCII characters pushed by the monitor's character encoder and serializes each one onto the `uart_tx` pin as an 8N1 frame at a fixed baud divisor. Its `tx_fifo_full` flag is the only flow control back to the encoder. It sits between the encoder and the board's UART TX pin.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `BAUD_DIV`, default 434: clocks per UART bit (50 MHz / 115200). Legal range is 2..65535.
- `clk` input 1: single system clock. All state updates on its rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `send_char` input 8: character to enqueue.
- `send_en` input 1: enqueue strobe. Sampled at the rising edge.
- `tx_fifo_full` output 1: FIFO holds 2^DEPTH_LOG2 entries. Combinational from registered count.
- `tx_busy` output 1: FIFO non-empty or a frame is in progress.
- `uart_tx` output 1: serial line, registered. Idles high.

## Operation
- **FIFO storage**
  - Circular buffer of 2^DEPTH_LOG2 × 8 bits.
  - `wptr` and `rptr` are DEPTH_LOG2 bits each and wrap modulo depth.
  - `count` is DEPTH_LOG2+1 bits.
- **Write**
  - Happens when `send_en & ~tx_fifo_full`: store `send_char` at `wptr`, then `wptr+1`.
  - `send_en` while full is silently dropped. Pointers and count do not change.
- **Pop**
  - Performed only by the FSM: read the entry at `rptr` into `shift[7:0]`, then `rptr+1`.
- **Simultaneous write and pop**
  - `count` is unchanged and both pointers advance.
  - When full, the write is still blocked in that cycle, because full is evaluated before the pop.
  - When empty, no pop occurs (the FSM sees empty), so the write lands normally.
- **FSM states:** IDLE, START, DATA, STOP.
- **Baud counter:** `bcnt` is 16 bits.
  - Loaded with BAUD_DIV-1 on every state entry and on every bit advance.
  - Decrements otherwise.
  - "Bit end" means `bcnt==0`.
- **Transitions**
  - IDLE: when count≠0, pop, go to START, and drive `uart_tx`=0.
  - START: at bit end, go to DATA with `bitidx`=0 and drive `uart_tx`=`shift[0]`.
  - DATA: at bit end, if `bitidx`<7, increment it, shift right, and drive the next bit (LSB first). If `bitidx`==7, go to STOP and drive `uart_tx`=1.
  - STOP: at bit end, if count≠0, pop, go directly to START, and drive `uart_tx`=0. Otherwise go to IDLE with `uart_tx`=1.
- **Derived outputs**
  - `tx_busy` = (state≠IDLE) | (count≠0).
  - `tx_fifo_full` = (count == 2^DEPTH_LOG2).
- **Reset**
  - Clears pointers, count, `bitidx` and `bcnt`.
  - State returns to IDLE and `uart_tx` to 1.
  - FIFO data contents are don't-care.
  - A reset mid-frame aborts the frame: the line returns high on the reset edge and queued characters are discarded.

## Timing
- **Reset values:** `uart_tx`=1, `tx_fifo_full`=0, `tx_busy`=0.
- **Write-to-line latency:** the write is captured at edge E0. The FSM pops at edge E1, and `uart_tx` is low from E1.
- **`tx_busy`:** high from E0.
- **Frame length:** exactly 10×BAUD_DIV clocks.
  - Start bit: BAUD_DIV clocks low.
  - 8 data bits: BAUD_DIV clocks each.
  - Stop bit: BAUD_DIV clocks high.
- **Back-to-back frames:** no idle gap. The next start bit begins on the clock immediately after the last stop-bit clock.
- **Full flag timing**
  - `tx_fifo_full` rises in the cycle after the write that fills the FIFO.
  - It falls in the cycle after the pop that frees an entry.
  - The encoder drives `send_en = ~tx_fifo_full`, so it issues no write in the full cycle and never loses characters.
- **Throughput:**
  - One write per clock is accepted until full.
  - Steady-state drain rate is one character per 10×BAUD_DIV clocks.
  - Up to 2^DEPTH_LOG2 characters can queue; one more is held in the shifter.

## Test plan
All scenarios use BAUD_DIV=4 and DEPTH_LOG2=4.

- **Reset:** assert `rst` for 2 clocks. Expect `uart_tx`=1, `tx_fifo_full`=0, `tx_busy`=0, with no activity for 100 clocks.
- **Single character:** `send_char`=0x41 ('A'), one `send_en` pulse.
  - `uart_tx` goes low 1 clock later and holds each bit 4 clocks.
  - Bit sequence: 0, 1,0,0,0,0,0,1,0, then 1.
  - Frame length is 40 clocks; `tx_busy` falls after the stop bit.
- **Burst to full:** 20 consecutive `send_en` cycles with `send_char` = 0x30..0x43.
  - The first char is popped at once, so `tx_fifo_full` rises after the 17th accepted write.
  - Chars 0x41–0x43 are dropped while full.
  - The line carries 0x30..0x40 in order, each frame exactly 40 clocks with no gaps.
- **Flow control with the encoder model:** `send_en = ~tx_fifo_full` producing the string "0000000c 00000013\r\n".
  - All 19 characters appear on the line in order.
- **Wrap-around:** 3 rounds of writing 10 chars and then draining.
  - Pointers wrap past 15, data stays in order, and count returns to 0 each round.
- **Mid-frame reset:** assert `rst` during data bit 3 of a frame while 5 chars are queued.
  - `uart_tx`=1 the next clock and stays idle.
  - `tx_busy`=0.
  - A fresh write after reset transmits correctly.
